// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the program counter and chooses the next fetch address.
// The fetch address advances sequentially, or it is redirected by a branch, a
// jump (J/JAL) or a jump-register (JR). After every redirect the IF/ID stage is
// flushed for a fixed number of bubbles. The PC is held while the pipeline
// stalls. Jump targets come from an external 26-to-32-bit concatenation unit,
// which this block also drives.
module pc_sequencer #(
    parameter logic [31:0] RESET_VEC    = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        stall_i,
    input  logic        br_taken_i,
    input  logic [15:0] br_imm_i,
    input  logic        j_req_i,
    input  logic [25:0] j_index_i,
    input  logic        jr_req_i,
    input  logic [31:0] jr_addr_i,
    output logic [25:0] conc_main_o,
    output logic [5:0]  conc_hi_o,
    input  logic [31:0] conc_result_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        fetch_valid_o,
    output logic        flush_o,
    output logic        misalign_o
);

    // Value loaded into the bubble counter when a redirect is taken (1..7).
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } seq_state_t;

    seq_state_t  state;
    logic [31:0] pc;
    logic [2:0]  flush_cnt;
    logic        fetch_valid;
    logic        flush;
    logic        misalign;

    logic [31:0] pc_plus4;
    logic [31:0] branch_offset;
    logic [31:0] branch_target;
    logic [31:0] raw_target;
    logic [31:0] aligned_target;
    logic        target_misaligned;
    logic        redirect;

    // Sequential address, sign-extended word-offset branch target, and the
    // concatenation unit feed. All additions wrap modulo 2^32.
    always_comb begin
        pc_plus4      = pc + 32'd4;
        branch_offset = {{14{br_imm_i[15]}}, br_imm_i, 2'b00};
        branch_target = pc_plus4 + branch_offset;
    end

    // Redirect target selection: JR wins over J/JAL, and J/JAL wins over a taken
    // branch. A misaligned target is forced onto a word boundary and flagged.
    always_comb begin
        redirect   = jr_req_i | j_req_i | br_taken_i;
        raw_target = pc_plus4;
        if (jr_req_i) begin
            raw_target = jr_addr_i;
        end else if (j_req_i) begin
            raw_target = conc_result_i;
        end else if (br_taken_i) begin
            raw_target = branch_target;
        end
        aligned_target    = raw_target & ~32'h3;
        target_misaligned = |raw_target[1:0];
    end

    // Sequencer FSM. It holds the PC, the bubble counter and the registered
    // status outputs. A redirect takes priority over a stall.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state       <= BOOT;
            pc          <= RESET_VEC;
            flush_cnt   <= 3'd0;
            fetch_valid <= 1'b0;
            flush       <= 1'b0;
            misalign    <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state       <= RUN;
                    fetch_valid <= 1'b1;
                    flush       <= 1'b0;
                    misalign    <= 1'b0;
                end
                RUN, FLUSH: begin
                    if (redirect) begin
                        pc          <= aligned_target;
                        flush_cnt   <= FLUSH_LOAD;
                        state       <= FLUSH;
                        flush       <= 1'b1;
                        fetch_valid <= 1'b0;
                        misalign    <= target_misaligned;
                    end else begin
                        misalign <= 1'b0;
                        if (!stall_i) begin
                            pc <= pc_plus4;
                        end
                        if (state == FLUSH) begin
                            if (flush_cnt <= 3'd1) begin
                                flush_cnt   <= 3'd0;
                                state       <= RUN;
                                flush       <= 1'b0;
                                fetch_valid <= 1'b1;
                            end else begin
                                flush_cnt   <= flush_cnt - 3'd1;
                                flush       <= 1'b1;
                                fetch_valid <= 1'b0;
                            end
                        end else begin
                            fetch_valid <= 1'b1;
                            flush       <= 1'b0;
                        end
                    end
                end
                default: begin
                    state       <= BOOT;
                    flush_cnt   <= 3'd0;
                    fetch_valid <= 1'b0;
                    flush       <= 1'b0;
                    misalign    <= 1'b0;
                end
            endcase
        end
    end

    // Output drive. The concatenation unit is fed every cycle, whether or not a
    // jump is requested.
    always_comb begin
        conc_main_o   = j_index_i;
        conc_hi_o     = pc_plus4[31:26];
        pc_o          = pc;
        pc_plus4_o    = pc_plus4;
        fetch_valid_o = fetch_valid;
        flush_o       = flush;
        misalign_o    = misalign;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: self-checking bench for pc_sequencer. It applies a directed
// vector table, hand-written multi-cycle sequences and a randomized run that is
// compared against a cycle-level reference model.
module tb_pc_sequencer;

    localparam logic [31:0] RESET_VEC    = 32'h0000_0000;
    localparam int          FLUSH_CYCLES = 2;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        stall;
    logic        br_taken;
    logic [15:0] br_imm;
    logic        j_req;
    logic [25:0] j_index;
    logic        jr_req;
    logic [31:0] jr_addr;
    logic [25:0] conc_main;
    logic [5:0]  conc_hi;
    logic [31:0] conc_result;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        flush;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(
        .RESET_VEC    (RESET_VEC),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .stall_i       (stall),
        .br_taken_i    (br_taken),
        .br_imm_i      (br_imm),
        .j_req_i       (j_req),
        .j_index_i     (j_index),
        .jr_req_i      (jr_req),
        .jr_addr_i     (jr_addr),
        .conc_main_o   (conc_main),
        .conc_hi_o     (conc_hi),
        .conc_result_i (conc_result),
        .pc_o          (pc),
        .pc_plus4_o    (pc_plus4),
        .fetch_valid_o (fetch_valid),
        .flush_o       (flush),
        .misalign_o    (misalign)
    );

    // External 26-to-32-bit concatenation unit.
    assign conc_result = {conc_hi, conc_main};

    // Free-running clock.
    always #5 Clk = ~Clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [15:0] imm;
        logic        j;
        logic [25:0] idx;
        logic        jr;
        logic [31:0] jr_addr;
        logic [31:0] exp_pc;
        logic        exp_valid;
        logic        exp_flush;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkVec(input logic rst, input logic stl, input logic br,
                                   input logic [15:0] imm, input logic j,
                                   input logic [25:0] idx, input logic jr,
                                   input logic [31:0] jra, input logic [31:0] epc,
                                   input logic ev, input logic ef, input logic em);
        vec_t v;
        v.rst = rst; v.stall = stl; v.br = br; v.imm = imm; v.j = j; v.idx = idx;
        v.jr = jr; v.jr_addr = jra; v.exp_pc = epc; v.exp_valid = ev;
        v.exp_flush = ef; v.exp_mis = em;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic driveInputs(input logic rst, input logic stl, input logic br,
                               input logic [15:0] imm, input logic j,
                               input logic [25:0] idx, input logic jr,
                               input logic [31:0] jra);
        Rst = rst; stall = stl; br_taken = br; br_imm = imm;
        j_req = j; j_index = idx; jr_req = jr; jr_addr = jra;
    endtask

    // Drive one cycle of inputs, clock them in, and settle 1 time unit past the edge.
    task automatic applyStimulus(input logic rst, input logic stl, input logic br,
                                 input logic [15:0] imm, input logic j,
                                 input logic [25:0] idx, input logic jr,
                                 input logic [31:0] jra);
        driveInputs(rst, stl, br, imm, j, idx, jr, jra);
        @(posedge Clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    endtask

    task automatic checkState(input string tag, input logic [31:0] epc, input logic ev,
                              input logic ef, input logic em);
        checkOutput({tag, " pc"}, pc, epc);
        checkOutput({tag, " pc_plus4"}, pc_plus4, epc + 32'd4);
        checkOutput({tag, " fetch_valid"}, {31'd0, fetch_valid}, {31'd0, ev});
        checkOutput({tag, " flush"}, {31'd0, flush}, {31'd0, ef});
        checkOutput({tag, " misalign"}, {31'd0, misalign}, {31'd0, em});
    endtask

    // Reference model state: fetch address, boot flag, bubbles still to come,
    // and the pending misalign pulse.
    logic [31:0] m_pc;
    bit          m_boot;
    int          m_flush_left;
    bit          m_mis;

    task automatic modelStep(input logic rst, input logic stl, input logic br,
                             input logic [15:0] imm, input logic j,
                             input logic [25:0] idx, input logic jr,
                             input logic [31:0] jra);
        logic [31:0] next_seq;
        logic [31:0] target;
        bit          have;
        next_seq = m_pc + 32'd4;
        have     = 1'b1;
        target   = 32'h0;
        if (rst) begin
            m_pc = RESET_VEC; m_boot = 1'b1; m_flush_left = 0; m_mis = 1'b0;
        end else if (m_boot) begin
            m_boot = 1'b0; m_mis = 1'b0;
        end else begin
            if (jr)      target = jra;
            else if (j)  target = {next_seq[31:26], idx};
            else if (br) target = next_seq + 32'($signed(imm)) * 32'd4;
            else         have = 1'b0;
            if (have) begin
                m_pc = {target[31:2], 2'b00};
                m_mis = (target % 4) != 0;
                m_flush_left = FLUSH_CYCLES;
            end else begin
                m_mis = 1'b0;
                if (!stl) m_pc = next_seq;
                if (m_flush_left > 0) m_flush_left--;
            end
        end
    endtask

    initial begin
        logic [31:0] tmp;
        logic        r_rst, r_stall, r_br, r_j, r_jr;
        logic [15:0] r_imm;
        logic [25:0] r_idx;
        logic [31:0] r_jra;

        // Directed vector table: inputs for one edge and the outputs expected after it.
        vecs.push_back(mkVec(1,0,0,16'h0,0,26'h0,0,32'h0,          32'h0,    0,0,0));
        vecs.push_back(mkVec(1,0,0,16'h0,0,26'h0,0,32'h0,          32'h0,    0,0,0));
        vecs.push_back(mkVec(0,0,0,16'h0,0,26'h0,0,32'h0,          32'h0,    1,0,0));
        vecs.push_back(mkVec(0,0,0,16'h0,0,26'h0,0,32'h0,          32'h4,    1,0,0));
        vecs.push_back(mkVec(0,0,0,16'h0,0,26'h0,0,32'h0,          32'h8,    1,0,0));
        vecs.push_back(mkVec(0,0,0,16'h0,0,26'h0,0,32'h0,          32'hC,    1,0,0));
        vecs.push_back(mkVec(0,0,0,16'h0,0,26'h0,1,32'hF8,         32'hF8,   0,1,0));
        vecs.push_back(mkVec(0,0,0,16'h0,0,26'h0,0,32'h0,          32'hFC,   0,1,0));
        vecs.push_back(mkVec(0,0,0,16'h0,0,26'h0,0,32'h0,          32'h100,  1,0,0));
        vecs.push_back(mkVec(0,0,1,16'hFFFE,0,26'h0,0,32'h0,       32'hFC,   0,1,0));
        vecs.push_back(mkVec(0,0,0,16'h0,0,26'h0,0,32'h0,          32'h100,  0,1,0));
        vecs.push_back(mkVec(0,0,0,16'h0,0,26'h0,0,32'h0,          32'h104,  1,0,0));
        vecs.push_back(mkVec(0,0,1,16'h0010,1,26'h123,1,32'h2000,  32'h2000, 0,1,0));
        vecs.push_back(mkVec(0,0,0,16'h0,0,26'h0,0,32'h0,          32'h2004, 0,1,0));
        vecs.push_back(mkVec(0,0,0,16'h0,0,26'h0,0,32'h0,          32'h2008, 1,0,0));
        vecs.push_back(mkVec(0,0,0,16'h0,0,26'h0,1,32'h38,         32'h38,   0,1,0));
        vecs.push_back(mkVec(0,0,0,16'h0,0,26'h0,0,32'h0,          32'h3C,   0,1,0));
        vecs.push_back(mkVec(0,0,0,16'h0,0,26'h0,0,32'h0,          32'h40,   1,0,0));
        vecs.push_back(mkVec(0,1,0,16'h0,0,26'h0,0,32'h0,          32'h40,   1,0,0));
        vecs.push_back(mkVec(0,1,0,16'h0,0,26'h0,0,32'h0,          32'h40,   1,0,0));
        vecs.push_back(mkVec(0,1,0,16'h0,0,26'h0,0,32'h0,          32'h40,   1,0,0));
        vecs.push_back(mkVec(0,1,0,16'h0,1,26'h100,0,32'h0,        32'h100,  0,1,0));
        vecs.push_back(mkVec(0,0,0,16'h0,0,26'h0,0,32'h0,          32'h104,  0,1,0));
        vecs.push_back(mkVec(0,0,0,16'h0,0,26'h0,0,32'h0,          32'h108,  1,0,0));
        vecs.push_back(mkVec(0,0,1,16'h0004,0,26'h0,0,32'h0,       32'h11C,  0,1,0));
        vecs.push_back(mkVec(0,1,0,16'h0,0,26'h0,0,32'h0,          32'h11C,  0,1,0));
        vecs.push_back(mkVec(0,0,0,16'h0,0,26'h0,0,32'h0,          32'h120,  1,0,0));
        vecs.push_back(mkVec(0,0,0,16'h0,0,26'h0,1,32'h203,        32'h200,  0,1,1));
        vecs.push_back(mkVec(0,0,0,16'h0,0,26'h0,0,32'h0,          32'h204,  0,1,0));
        vecs.push_back(mkVec(0,0,0,16'h0,0,26'h0,0,32'h0,          32'h208,  1,0,0));

        driveInputs(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        @(negedge Clk);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].imm,
                          vecs[i].j, vecs[i].idx, vecs[i].jr, vecs[i].jr_addr);
            checkState($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_valid,
                       vecs[i].exp_flush, vecs[i].exp_mis);
        end

        // Jump through the concatenation unit to a misaligned top-of-memory
        // target, then wrap around to zero.
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'hFC00_0000);
        checkState("jhi_setup", 32'hFC00_0000, 0, 1, 0);
        idleCycle();
        idleCycle();
        checkState("jhi_run", 32'hFC00_0008, 1, 0, 0);
        driveInputs(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 26'h3FF_FFFD, 1'b0, 32'h0);
        #1;
        checkOutput("conc_hi", {26'd0, conc_hi}, 32'h3F);
        checkOutput("conc_main", {6'd0, conc_main}, 32'h03FF_FFFD);
        checkOutput("conc_result", conc_result, 32'hFFFF_FFFD);
        @(posedge Clk);
        #1;
        checkState("jhi_target", 32'hFFFF_FFFC, 0, 1, 1);
        checkOutput("wrap_plus4", pc_plus4, 32'h0);
        idleCycle();
        checkState("jhi_wrap", 32'h0, 0, 1, 0);
        idleCycle();
        checkState("jhi_after", 32'h4, 1, 0, 0);

        // A redirect in the first flush cycle restarts the bubble count.
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h500);
        checkState("refl_a", 32'h500, 0, 1, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h600);
        checkState("refl_b", 32'h600, 0, 1, 0);
        idleCycle();
        checkState("refl_c", 32'h604, 0, 1, 0);
        idleCycle();
        checkState("refl_d", 32'h608, 1, 0, 0);

        // Reset in the middle of a flush discards the pending bubbles.
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h700);
        checkState("rstfl_a", 32'h700, 0, 1, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        checkState("rstfl_b", RESET_VEC, 0, 0, 0);
        idleCycle();
        checkState("rstfl_c", RESET_VEC, 1, 0, 0);

        // Randomized run compared against the reference model.
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        modelStep(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        for (int c = 0; c < 600; c++) begin
            tmp = m_pc + 32'd4;
            checkState($sformatf("rnd%0d", c), m_pc,
                       !m_boot && (m_flush_left == 0), m_flush_left > 0, m_mis);
            checkOutput($sformatf("rnd%0d conc_hi", c), {26'd0, conc_hi}, {26'd0, tmp[31:26]});
            r_rst   = ($urandom_range(0, 79) == 0);
            r_stall = ($urandom_range(0, 3) == 0);
            r_br    = ($urandom_range(0, 7) == 0);
            r_j     = ($urandom_range(0, 9) == 0);
            r_jr    = ($urandom_range(0, 11) == 0);
            r_imm   = 16'($urandom);
            r_idx   = 26'($urandom);
            r_jra   = $urandom;
            applyStimulus(r_rst, r_stall, r_br, r_imm, r_j, r_idx, r_jr, r_jra);
            modelStep(r_rst, r_stall, r_br, r_imm, r_j, r_idx, r_jr, r_jra);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
